// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single memory port between NUM_REQ requesters that
//               speak the engine memory protocol (op 01=read, 11=write,
//               00=none; addr/data held until opdone; opdone is a one-cycle
//               pulse). Round-robin arbitration with one access in flight.
//               A watchdog completes any access that stalls for TIMEOUT
//               cycles and flags it with req_error_o.
//
// Ports       :
//   clk             in   1                 clock, all logic on posedge
//   reset           in   1                 synchronous, active-high
//   req_op_i        in   2*NUM_REQ         requester n op at [2n+1:2n]
//   req_addr_i      in   ADDR_BW*NUM_REQ   per-requester address
//   req_data_i      in   DATA_BW*NUM_REQ   per-requester write data
//   req_data_o      out  DATA_BW           read data, valid with req_opdone_o
//   req_opdone_o    out  NUM_REQ           one-hot completion pulse
//   req_error_o     out  NUM_REQ           one-hot timeout pulse
//   mem_operation_o out  2                 operation to memory
//   mem_addr_o      out  ADDR_BW           address to memory
//   mem_data_o      out  DATA_BW           write data to memory
//   mem_data_i      in   DATA_BW           read data from memory
//   mem_opdone_i    in   1                 access complete from memory
//   grant_o         out  NUM_REQ           one-hot current owner, 0 when idle
//   busy_o          out  1                 high while an access is owned
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_BW = 32,
    parameter int DATA_BW = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2*NUM_REQ-1:0]         req_op_i,
    input  logic [ADDR_BW*NUM_REQ-1:0]   req_addr_i,
    input  logic [DATA_BW*NUM_REQ-1:0]   req_data_i,
    output logic [DATA_BW-1:0]           req_data_o,
    output logic [NUM_REQ-1:0]           req_opdone_o,
    output logic [NUM_REQ-1:0]           req_error_o,
    output logic [1:0]                   mem_operation_o,
    output logic [ADDR_BW-1:0]           mem_addr_o,
    output logic [DATA_BW-1:0]           mem_data_o,
    input  logic [DATA_BW-1:0]           mem_data_i,
    input  logic                         mem_opdone_i,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [SUM_W-1:0]   c_NUM_REQ  = SUM_W'(NUM_REQ);
    localparam logic [TMR_W-1:0]   c_TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);
    localparam logic [1:0]         c_OP_NONE  = 2'b00;
    localparam logic [1:0]         c_OP_READ  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    // Per-requester views of the flattened request buses
    logic [1:0]         w_req_op   [NUM_REQ];
    logic [ADDR_BW-1:0] w_req_addr [NUM_REQ];
    logic [DATA_BW-1:0] w_req_data [NUM_REQ];

    generate
        for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
            assign w_req_op[n]   = req_op_i[2*n +: 2];
            assign w_req_addr[n] = req_addr_i[ADDR_BW*n +: ADDR_BW];
            assign w_req_data[n] = req_data_i[DATA_BW*n +: DATA_BW];
        end
    endgenerate

    logic [IDX_W-1:0]   r_grant_idx, w_grant_idx_next;
    logic [IDX_W-1:0]   r_rr_ptr,    w_rr_ptr_next;
    logic [TMR_W-1:0]   r_timer,     w_timer_next;
    logic [NUM_REQ-1:0] r_grant,     w_grant_next;
    logic [NUM_REQ-1:0] r_opdone,    w_opdone_next;
    logic [NUM_REQ-1:0] r_error,     w_error_next;
    logic [DATA_BW-1:0] r_rdata,     w_rdata_next;
    logic [1:0]         r_mem_op,    w_mem_op_next;
    logic [ADDR_BW-1:0] r_mem_addr,  w_mem_addr_next;
    logic [DATA_BW-1:0] r_mem_data,  w_mem_data_next;
    logic               r_busy,      w_busy_next;

    // Round-robin pick: first requester at or after r_rr_ptr, wrapping.
    // Only op bit 0 matters: 01 and 11 request, 10 and 00 do not.
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [SUM_W-1:0]   w_sum;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + SUM_W'(i);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            if (!w_found && w_req_op[w_sum[IDX_W-1:0]][0]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IDX_W-1:0];
            end
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        w_state_next     = r_state;
        w_grant_idx_next = r_grant_idx;
        w_rr_ptr_next    = r_rr_ptr;
        w_timer_next     = r_timer;
        w_grant_next     = r_grant;
        w_opdone_next    = r_opdone;
        w_error_next     = r_error;
        w_rdata_next     = r_rdata;
        w_mem_op_next    = r_mem_op;
        w_mem_addr_next  = r_mem_addr;
        w_mem_data_next  = r_mem_data;
        w_busy_next      = r_busy;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_idx_next = w_pick;
                    w_grant_next     = c_ONE << w_pick;
                    w_mem_op_next    = w_req_op[w_pick];
                    w_mem_addr_next  = w_req_addr[w_pick];
                    w_mem_data_next  = w_req_data[w_pick];
                    w_busy_next      = 1'b1;
                    w_timer_next     = '0;
                    w_state_next     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // A real completion takes priority over a coincident timeout.
                if (mem_opdone_i) begin
                    w_opdone_next = c_ONE << r_grant_idx;
                    w_rdata_next  = (r_mem_op == c_OP_READ) ? mem_data_i : '0;
                    w_mem_op_next = c_OP_NONE;
                    w_state_next  = ST_RELEASE;
                end else if (r_timer == c_TMR_LAST) begin
                    w_opdone_next = c_ONE << r_grant_idx;
                    w_error_next  = c_ONE << r_grant_idx;
                    w_rdata_next  = '0;
                    w_mem_op_next = c_OP_NONE;
                    w_state_next  = ST_RELEASE;
                end else begin
                    w_timer_next = r_timer + TMR_W'(1);
                end
            end

            ST_RELEASE: begin
                // One dead cycle lets the finished requester drop or change
                // its request before the next arbitration.
                w_rr_ptr_next   = (r_grant_idx == c_LAST_IDX) ? '0 : r_grant_idx + IDX_W'(1);
                w_grant_next    = '0;
                w_opdone_next   = '0;
                w_error_next    = '0;
                w_rdata_next    = '0;
                w_mem_op_next   = c_OP_NONE;
                w_mem_addr_next = '0;
                w_mem_data_next = '0;
                w_busy_next     = 1'b0;
                w_state_next    = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_timer     <= '0;
            r_grant     <= '0;
            r_opdone    <= '0;
            r_error     <= '0;
            r_rdata     <= '0;
            r_mem_op    <= c_OP_NONE;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_grant_idx <= w_grant_idx_next;
            r_rr_ptr    <= w_rr_ptr_next;
            r_timer     <= w_timer_next;
            r_grant     <= w_grant_next;
            r_opdone    <= w_opdone_next;
            r_error     <= w_error_next;
            r_rdata     <= w_rdata_next;
            r_mem_op    <= w_mem_op_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_data  <= w_mem_data_next;
            r_busy      <= w_busy_next;
        end
    end

    assign grant_o         = r_grant;
    assign req_opdone_o    = r_opdone;
    assign req_error_o     = r_error;
    assign req_data_o      = r_rdata;
    assign mem_operation_o = r_mem_op;
    assign mem_addr_o      = r_mem_addr;
    assign mem_data_o      = r_mem_data;
    assign busy_o          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A vector table of
//               single accesses, hand sequences for contention, bursts and
//               reset mid-access, and a scoreboard of expected completions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_BW = 32;
    localparam int DATA_BW = 32;
    localparam int TIMEOUT = 4;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [2*NUM_REQ-1:0]       req_op_i;
    logic [ADDR_BW*NUM_REQ-1:0] req_addr_i;
    logic [DATA_BW*NUM_REQ-1:0] req_data_i;
    logic [DATA_BW-1:0]         req_data_o;
    logic [NUM_REQ-1:0]         req_opdone_o;
    logic [NUM_REQ-1:0]         req_error_o;
    logic [1:0]                 mem_operation_o;
    logic [ADDR_BW-1:0]         mem_addr_o;
    logic [DATA_BW-1:0]         mem_data_o;
    logic [DATA_BW-1:0]         mem_data_i;
    logic                       mem_opdone_i;
    logic [NUM_REQ-1:0]         grant_o;
    logic                       busy_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_BW (ADDR_BW),
        .DATA_BW (DATA_BW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_op_i        (req_op_i),
        .req_addr_i      (req_addr_i),
        .req_data_i      (req_data_i),
        .req_data_o      (req_data_o),
        .req_opdone_o    (req_opdone_o),
        .req_error_o     (req_error_o),
        .mem_operation_o (mem_operation_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_o      (mem_data_o),
        .mem_data_i      (mem_data_i),
        .mem_opdone_i    (mem_opdone_i),
        .grant_o         (grant_o),
        .busy_o          (busy_o)
    );

    // Memory model: completes mem_lat cycles after an op appears (0 = never)
    int                 mem_lat   = 0;
    logic [DATA_BW-1:0] mem_rdata = '0;
    int                 mem_cnt   = 0;

    always @(posedge clk) begin
        mem_cnt <= (mem_operation_o == 2'b00) ? 0 : mem_cnt + 1;
    end
    assign mem_opdone_i = (mem_operation_o != 2'b00) && (mem_lat != 0) && (mem_cnt == mem_lat - 1);
    assign mem_data_i   = mem_rdata;

    // Checking infrastructure
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int n);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int n, input logic [1:0] op,
                           input logic [ADDR_BW-1:0] a, input logic [DATA_BW-1:0] d);
        req_op_i[2*n +: 2]              = op;
        req_addr_i[ADDR_BW*n +: ADDR_BW] = a;
        req_data_i[DATA_BW*n +: DATA_BW] = d;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (req_opdone_o != '0) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Scoreboard: expectations are queued when a request is driven and
    // popped on each completion pulse.
    typedef struct {
        logic [NUM_REQ-1:0] done;
        logic [DATA_BW-1:0] data;
        logic [NUM_REQ-1:0] err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            if (req_opdone_o != '0) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_opdone", 64'(req_opdone_o), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_opdone", 64'(req_opdone_o), 64'(mon_e.done));
                    check("sb_data",   64'(req_data_o),   64'(mon_e.data));
                    check("sb_error",  64'(req_error_o),  64'(mon_e.err));
                end
            end else if (req_error_o != '0) begin
                check("stray_error", 64'(req_error_o), 64'd0);
            end
        end
    end

    // Single-access vectors
    typedef struct {
        int                 req;
        logic [1:0]         op;
        logic [ADDR_BW-1:0] addr;
        logic [DATA_BW-1:0] wdata;
        int                 lat;
        logic [DATA_BW-1:0] rdata;
        logic [DATA_BW-1:0] exp_data;
        int                 exp_lat;
        bit                 exp_err;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int cyc;
        mem_lat   = v.lat;
        mem_rdata = v.rdata;
        set_req(v.req, v.op, v.addr, v.wdata);
        sb_q.push_back('{done: onehot(v.req), data: v.exp_data,
                         err: (v.exp_err ? onehot(v.req) : '0)});
        @(negedge clk);
        check("vec_grant",    64'(grant_o),         64'(onehot(v.req)));
        check("vec_mem_op",   64'(mem_operation_o), 64'(v.op));
        check("vec_mem_addr", 64'(mem_addr_o),      64'(v.addr));
        check("vec_mem_data", 64'(mem_data_o),      64'(v.wdata));
        check("vec_busy",     64'(busy_o),          64'd1);
        wait_done(12, cyc);
        check("vec_done_latency", 64'(cyc), 64'(v.exp_lat));
        check("vec_mem_op_cleared", 64'(mem_operation_o), 64'd0);
        check("vec_busy_release", 64'(busy_o), 64'd1);
        set_req(v.req, 2'b00, '0, '0);
        @(negedge clk);
        check("vec_idle_grant",  64'(grant_o),      64'd0);
        check("vec_idle_busy",   64'(busy_o),       64'd0);
        check("vec_idle_opdone", 64'(req_opdone_o), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int cyc;
        int ndone;
        int nacc;
        int bad;
        int t[6];
        bit prev_op;

        vecs[0] = '{req: 0, op: 2'b01, addr: 32'h10, wdata: 32'h0,    lat: 3, rdata: 32'hABCD, exp_data: 32'hABCD, exp_lat: 3, exp_err: 1'b0};
        vecs[1] = '{req: 1, op: 2'b11, addr: 32'h20, wdata: 32'h55,   lat: 2, rdata: 32'hDEAD, exp_data: 32'h0,    exp_lat: 2, exp_err: 1'b0};
        vecs[2] = '{req: 0, op: 2'b01, addr: 32'h30, wdata: 32'h0,    lat: 0, rdata: 32'hBEEF, exp_data: 32'h0,    exp_lat: 4, exp_err: 1'b1};
        vecs[3] = '{req: 1, op: 2'b01, addr: 32'h44, wdata: 32'h7,    lat: 4, rdata: 32'h1234, exp_data: 32'h1234, exp_lat: 4, exp_err: 1'b0};
        vecs[4] = '{req: 1, op: 2'b01, addr: 32'h48, wdata: 32'h0,    lat: 5, rdata: 32'h5678, exp_data: 32'h0,    exp_lat: 4, exp_err: 1'b1};
        vecs[5] = '{req: 0, op: 2'b11, addr: 32'h50, wdata: 32'hA5A5, lat: 1, rdata: 32'hFFFF, exp_data: 32'h0,    exp_lat: 1, exp_err: 1'b0};

        reset      = 1'b1;
        req_op_i   = '0;
        req_addr_i = '0;
        req_data_i = '0;
        t          = '{default: 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grant",  64'(grant_o),         64'd0);
        check("rst_busy",   64'(busy_o),          64'd0);
        check("rst_mem_op", 64'(mem_operation_o), 64'd0);
        check("rst_addr",   64'(mem_addr_o),      64'd0);
        check("rst_opdone", 64'({req_opdone_o, req_error_o}), 64'd0);
        check("rst_rdata",  64'(req_data_o),      64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Code 10 is not a request
        set_req(0, 2'b10, 32'h99, 32'h0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (grant_o != '0 || mem_operation_o != 2'b00) bad++;
        end
        check("op10_ignored", 64'(bad), 64'd0);
        set_req(0, 2'b00, '0, '0);
        @(negedge clk);

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // Contention from reset: both requesters read continuously
        reset = 1'b1;
        set_req(0, 2'b01, 32'hA0, '0);
        set_req(1, 2'b01, 32'hB0, '0);
        mem_lat   = 1;
        mem_rdata = 32'hC0DE;
        for (int k = 0; k < 6; k++)
            sb_q.push_back('{done: onehot(k % 2), data: 32'hC0DE, err: '0});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        cyc   = 0;
        while (ndone < 6 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (req_opdone_o != '0) begin
                t[ndone] = cyc;
                check("cont_grant", 64'(grant_o), 64'(onehot(ndone % 2)));
                check("cont_addr",  64'(mem_addr_o), (ndone % 2 == 1) ? 64'hB0 : 64'hA0);
                ndone++;
                if (ndone == 6) begin
                    set_req(0, 2'b00, '0, '0);
                    set_req(1, 2'b00, '0, '0);
                end
            end
        end
        check("cont_count", 64'(ndone), 64'd6);
        check("cont_gap", 64'(t[1] - t[0]), 64'd3);
        for (int i = 0; i < 4; i++) check("cont_period", 64'(t[i+2] - t[i]), 64'd6);
        repeat (2) @(negedge clk);

        // Burst: req0 holds op=01 and steps addr on each opdone
        mem_lat = 1;
        set_req(0, 2'b01, 32'h0, '0);
        for (int k = 0; k < 4; k++)
            sb_q.push_back('{done: 2'b01, data: 32'h100 + k, err: '0});
        nacc    = 0;
        ndone   = 0;
        prev_op = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_operation_o != 2'b00 && !prev_op) begin
                check("burst_addr", 64'(mem_addr_o), 64'(nacc));
                mem_rdata = 32'h100 + nacc;
                nacc++;
            end
            prev_op = (mem_operation_o != 2'b00);
            if (req_opdone_o != '0) begin
                ndone++;
                if (ndone == 4) set_req(0, 2'b00, '0, '0);
                else            set_req(0, 2'b01, 32'(ndone), '0);
            end
        end
        check("burst_accesses", 64'(nacc), 64'd4);
        check("burst_opdones",  64'(ndone), 64'd4);

        // Reset mid-WAIT: advance rr_ptr to 1, then abandon a req1 access
        mem_lat   = 1;
        mem_rdata = 32'h77;
        set_req(0, 2'b01, 32'h60, '0);
        sb_q.push_back('{done: 2'b01, data: 32'h77, err: '0});
        wait_done(10, cyc);
        check("pre_reset_done_seen", 64'(cyc != 0), 64'd1);
        set_req(0, 2'b00, '0, '0);
        @(negedge clk);
        mem_lat = 0;
        set_req(1, 2'b01, 32'h70, '0);
        @(negedge clk);
        check("midwait_grant", 64'(grant_o), 64'b10);
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 2'b01, 32'h80, '0);
        @(negedge clk);
        check("midwait_rst_grant",  64'(grant_o),         64'd0);
        check("midwait_rst_busy",   64'(busy_o),          64'd0);
        check("midwait_rst_mem_op", 64'(mem_operation_o), 64'd0);
        check("midwait_rst_addr",   64'(mem_addr_o),      64'd0);
        check("midwait_rst_done",   64'({req_opdone_o, req_error_o}), 64'd0);
        mem_lat   = 1;
        mem_rdata = 32'h99;
        sb_q.push_back('{done: 2'b01, data: 32'h99, err: '0});
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_grant", 64'(grant_o),    64'b01);
        check("post_rst_addr",  64'(mem_addr_o), 64'h80);
        wait_done(10, cyc);
        check("post_rst_done_seen", 64'(cyc != 0), 64'd1);
        set_req(0, 2'b00, '0, '0);
        set_req(1, 2'b00, '0, '0);
        repeat (4) @(negedge clk);

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
